// File: rtl/stage_mem.sv
// stage_mem: memory-access stage of the mini-processor pipeline.
// Stores complete in one cycle. Loads take two cycles: an issue cycle that
// stalls the pipeline, then a LOAD cycle that presents the read data.
module stage_mem #(
  parameter int data_width = 32,
  parameter int reg_addr   = 3,
  parameter int mem_addr   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  MemRd_in,
  input  logic                  MemWr_in,
  input  logic                  WRegEn_in,
  input  logic [reg_addr-1:0]   wReg1_in,
  input  logic [data_width-1:0] alu_in,
  input  logic [data_width-1:0] store_in,
  output logic                  WRegEn_out,
  output logic [reg_addr-1:0]   wReg1_out,
  output logic [data_width-1:0] wdata_out,
  output logic                  stall_out
);

  localparam int DEPTH = 1 << mem_addr;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [data_width-1:0] mem [DEPTH];
  logic [data_width-1:0] rd_data;
  logic [mem_addr-1:0]   addr;
  logic                  rd_issue;
  logic                  wr_en;

  // Upper address bits are dropped, so addresses wrap around the memory.
  assign addr = alu_in[mem_addr-1:0];

  // A simultaneous read+write request is treated as a store only.
  assign rd_issue = ~reset & enable & (state == IDLE) & MemRd_in & ~MemWr_in;
  assign wr_en    = ~reset & enable & (state == IDLE) & MemWr_in;

  // State register; reset abandons any load in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: enter LOAD on an issued read, leave it on the next enabled edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_issue) state_nxt = LOAD;
      LOAD:    if (enable)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data memory: synchronous write, read data registered on the issuing edge.
  always_ff @(posedge clk) begin
    if (wr_en)    mem[addr] <= store_in;
    if (rd_issue) rd_data   <= mem[addr];
  end

  // Write-back outputs; a load's write enable only appears in its LOAD cycle.
  assign stall_out  = rd_issue;
  assign wReg1_out  = wReg1_in;
  assign wdata_out  = (state == LOAD) ? rd_data : alu_in;
  assign WRegEn_out = WRegEn_in & ~stall_out & ~reset;

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access stage of the mini-processor pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register `stage_MEM_WB`. It owns the word-addressed data memory and executes stores in one cycle and loads in two. It drives the write-back triple (`WRegEn_out`, `wReg1_out`, `wdata_out`) that MEM/WB captures. During the first cycle of a load it raises `stall_out` so the upstream registers and MEM/WB hold.

## Interface
- `data_width`, 32, datapath and memory word width
- `reg_addr`, 3, register-file address width
- `mem_addr`, 8, data-memory word-address width (depth 2^mem_addr)

- `clk`  in  1  pipeline clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; one clock, async active-high reset, fixed
- `enable`  in  1  global pipeline enable; low freezes the stage
- `MemRd_in`  in  1  load request from EX/MEM
- `MemWr_in`  in  1  store request from EX/MEM
- `WRegEn_in`  in  1  register write enable from EX/MEM
- `wReg1_in`  in  reg_addr  destination register from EX/MEM
- `alu_in`  in  data_width  ALU result, also the memory word address (low `mem_addr` bits)
- `store_in`  in  data_width  store data
- `WRegEn_out`  out  1  write enable to MEM/WB
- `wReg1_out`  out  reg_addr  destination register to MEM/WB
- `wdata_out`  out  data_width  write-back data to MEM/WB
- `stall_out`  out  1  hold request to EX/MEM and MEM/WB; their enable is `enable & ~stall_out`

## Operation
- Memory: 2^mem_addr × data_width array with a synchronous write and a synchronous read. The read data register is loaded on the issuing edge. Contents are not reset.
- Address is `alu_in[mem_addr-1:0]`. Upper bits are ignored, so addresses wrap.
- FSM states:
  - IDLE to LOAD when `enable & MemRd_in & ~MemWr_in`. The read is issued on that edge.
  - LOAD to IDLE when `enable`.
  - LOAD holds while `enable` is low.
- Store: in IDLE with `enable & MemWr_in`, write `store_in` at the address on the rising edge. No stall.
- `MemRd_in & MemWr_in` is illegal. It is treated as a store only: no read, no stall.
- `stall_out = ~reset & (state==IDLE) & MemRd_in & ~MemWr_in & enable`. It is combinational from the inputs and state.
- `wdata_out`:
  - In LOAD: the registered read data.
  - Otherwise: `alu_in`.
- `wReg1_out = wReg1_in`, combinational pass-through.
- `WRegEn_out = WRegEn_in & ~stall_out & ~reset`. A load's write enable is presented only in the LOAD cycle.
- `enable` low: no memory write, no read issue, FSM holds, `stall_out` = 0. Outputs still follow state and inputs.

## Timing
- Reset, asserted async:
  - FSM goes to IDLE immediately.
  - `stall_out` = 0 and `WRegEn_out` = 0 while reset is high.
  - `wReg1_out` follows `wReg1_in`; `wdata_out` follows `alu_in`.
  - The read-data register is don't-care.
- Reset mid-load: the load is abandoned. After release the FSM is in IDLE and the load is not replayed.
- Store latency: 1 cycle. Memory is updated at the edge ending the cycle in which the store is presented.
- Load latency: 2 cycles.
  - Cycle N: request presented, `stall_out` = 1, `WRegEn_out` = 0.
  - Cycle N+1: LOAD state, data on `wdata_out`, `stall_out` = 0, `WRegEn_out` = `WRegEn_in`. MEM/WB captures at the end of N+1.
- Upstream holds `MemRd_in`, `wReg1_in`, `alu_in` and `WRegEn_in` stable across N and N+1 because EX/MEM is held by `stall_out`.
- Store at cycle N followed by a load of the same address at N+1: the load returns the new value, since the write completes before the read edge.
- Back-to-back loads: each takes 2 cycles. The second load's stall cycle immediately follows the first load's LOAD cycle.

## Test plan
- Reset: assert `reset` with `MemRd_in=1`, `WRegEn_in=1` → `stall_out=0`, `WRegEn_out=0`. After release the FSM is in IDLE.
- Store/load: store `store_in=32'hDEADBEEF` at `alu_in=5`, then load `alu_in=5`, `wReg1_in=3`, `WRegEn_in=1`.
  - Stall cycle: `stall_out=1`, `WRegEn_out=0`.
  - Next cycle: `wdata_out=32'hDEADBEEF`, `wReg1_out=3`, `WRegEn_out=1`.
- Wrap: store `32'h1234` at `alu_in=32'h105` (mem_addr=8), then load `alu_in=5` → `32'h1234`.
- ALU pass-through: `MemRd_in=0`, `MemWr_in=0`, `alu_in=32'h77`, `WRegEn_in=1` → `wdata_out=32'h77`, `WRegEn_out=1`, `stall_out=0` every cycle.
- Freeze and abort:
  - Drop `enable` during LOAD for 3 cycles → FSM stays in LOAD, no memory change, `wdata_out` holds the load data.
  - Assert `reset` during LOAD → IDLE, `WRegEn_out=0`.
- Illegal and back-to-back:
  - `MemRd_in=MemWr_in=1`, `store_in=9` at address 2 → no stall, a later load of address 2 returns 9.
  - Two consecutive loads → `stall_out` pattern 1,0,1,0.
